// File: rtl/timer_countdown_pkg.sv
// Shared timer definitions: digit/time widths, digit maxima and load clamping.
package timer_countdown_pkg;

    localparam int DIGIT_W = 4;
    localparam int TIME_W  = 16;

    localparam logic [DIGIT_W-1:0] MAX_ONES = 4'd9;
    localparam logic [DIGIT_W-1:0] MAX_TENS = 4'd5;

    // Saturate an out-of-range digit to its maximum legal value.
    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d,
                                                       input logic [DIGIT_W-1:0] mx);
        return (d > mx) ? mx : d;
    endfunction

endpackage

// File: rtl/timer_countdown_bcd_digit_down.sv
// One BCD down-counting digit. A borrow-in decrements it; decrementing from 0
// wraps to MAX and raises borrow-out towards the next higher digit.
module bcd_digit_down
    import timer_countdown_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MAX = MAX_ONES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_clear,
    input  logic               i_load,
    input  logic [DIGIT_W-1:0] i_din,
    input  logic               i_borrow_in,
    output logic               o_borrow_out,
    output logic [DIGIT_W-1:0] o_q
);

    logic [DIGIT_W-1:0] r_q;

    // Digit register: clear beats load beats decrement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)            r_q <= '0;
        else if (i_clear)     r_q <= '0;
        else if (i_load)      r_q <= i_din;
        else if (i_borrow_in) r_q <= (r_q == '0) ? MAX : r_q - 4'd1;
    end

    assign o_borrow_out = i_borrow_in && (r_q == '0);
    assign o_q          = r_q;

endmodule

// File: rtl/timer_countdown.sv
// MM:SS BCD countdown timer with load/clear, run gating and a done pulse.
// The count stops at 00:00; an invalid load is either clamped or rejected.
module timer_countdown
    import timer_countdown_pkg::*;
#(
    parameter int CLAMP_INVALID = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [TIME_W-1:0] din,
    input  logic              tick,
    input  logic              run,
    input  logic              clear,
    output logic [TIME_W-1:0] dout,
    output logic              zero,
    output logic              done,
    output logic              load_err
);

    logic              w_valid;
    logic              w_load_req;
    logic              w_load_en;
    logic              w_step;
    logic [TIME_W-1:0] w_load_val;
    logic              w_b_s1, w_b_s10, w_b_m1, w_b_m10;
    logic              r_done;
    logic              r_load_err;

    assign w_valid = (din[15:12] <= MAX_ONES) && (din[11:8] <= MAX_ONES) &&
                     (din[7:4]   <= MAX_TENS) && (din[3:0]  <= MAX_ONES);

    // When the load is accepted, clamped digits equal din for a valid value.
    assign w_load_val = {clamp_digit(din[15:12], MAX_ONES), clamp_digit(din[11:8], MAX_ONES),
                         clamp_digit(din[7:4],   MAX_TENS), clamp_digit(din[3:0],  MAX_ONES)};

    assign w_load_req = load && !clear;
    assign w_load_en  = w_load_req && ((CLAMP_INVALID != 0) || w_valid);
    // Gating on nonzero keeps 00:00 from wrapping to 99:59.
    assign w_step     = tick && run && !clear && !load && !zero;

    bcd_digit_down #(.MAX(MAX_ONES)) u_s1 (
        .clk(clk), .reset(reset), .i_clear(clear), .i_load(w_load_en),
        .i_din(w_load_val[3:0]), .i_borrow_in(w_step), .o_borrow_out(w_b_s1), .o_q(dout[3:0]));

    bcd_digit_down #(.MAX(MAX_TENS)) u_s10 (
        .clk(clk), .reset(reset), .i_clear(clear), .i_load(w_load_en),
        .i_din(w_load_val[7:4]), .i_borrow_in(w_b_s1), .o_borrow_out(w_b_s10), .o_q(dout[7:4]));

    bcd_digit_down #(.MAX(MAX_ONES)) u_m1 (
        .clk(clk), .reset(reset), .i_clear(clear), .i_load(w_load_en),
        .i_din(w_load_val[11:8]), .i_borrow_in(w_b_s10), .o_borrow_out(w_b_m1), .o_q(dout[11:8]));

    bcd_digit_down #(.MAX(MAX_ONES)) u_m10 (
        .clk(clk), .reset(reset), .i_clear(clear), .i_load(w_load_en),
        .i_din(w_load_val[15:12]), .i_borrow_in(w_b_m1), .o_borrow_out(w_b_m10), .o_q(dout[15:12]));

    // Status pulses: done when a step leaves 00:01, load_err on a rejected load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_done     <= w_step && (dout == 16'h0001);
            r_load_err <= w_load_req && !w_valid && (CLAMP_INVALID == 0);
        end
    end

    assign zero     = (dout == '0);
    assign done     = r_done;
    assign load_err = r_load_err;

    // Borrow out of the minute tens is unreachable because steps stop at zero.
    logic w_unused;
    assign w_unused = w_b_m10;

endmodule

// File: doc/timer_countdown.md
TIMER_COUNTDOWN -- requirements
Module: timer_countdown

Interface
REQ-001 Parameter CLAMP_INVALID, default 1, selects invalid-BCD load handling: 1 = clamp digits, 0 = reject the load.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 load  input  1  one-cycle request to load din into the counter.
REQ-005 din  input  16  BCD time MM:SS; [15:12] minute tens, [11:8] minute ones, [7:4] second tens, [3:0] second ones.
REQ-006 tick  input  1  one-cycle 1 Hz enable pulse from the prescaler.
REQ-007 run  input  1  level; counting is permitted only while high (start/pause).
REQ-008 clear  input  1  one-cycle request to force the counter to 00:00.
REQ-009 dout  output  16  registered BCD current time, same digit layout as din.
REQ-010 zero  output  1  high whenever dout equals 16'h0000.
REQ-011 done  output  1  one-cycle pulse when a count step reaches 00:00.
REQ-012 load_err  output  1  one-cycle pulse when a load is rejected (CLAMP_INVALID=0 only).

Function
REQ-013 Per-cycle priority SHALL be clear > load > (tick AND run); lower-priority events in the same cycle are dropped.
REQ-014 clear SHALL set dout to 0000 on the next edge without asserting done.
REQ-015 load SHALL update dout on the next edge (latency 1); done is not asserted by a load, even of 0000.
REQ-016 Validity: minute digits and second ones must be <=9; second tens must be <=5.
REQ-017 CLAMP_INVALID=1: each invalid digit loads its maximum (9, or 5 for second tens); valid digits load unchanged.
REQ-018 CLAMP_INVALID=0: an invalid din leaves dout unchanged and pulses load_err in the next cycle.
REQ-019 A count step (tick AND run, no clear/load, dout nonzero) SHALL decrement dout by one second on the next edge.
REQ-020 Borrow chain: second ones 0->9 borrows from second tens; second tens 0->5 borrows from minute ones; minute ones 0->9 borrows from minute tens.
REQ-021 At 00:00 a count step SHALL leave dout at 0000 (no wrap to 99:59) and SHALL NOT pulse done.
REQ-022 done SHALL pulse in the cycle after the edge where a count step changes dout from 00:01 to 00:00.
REQ-023 zero SHALL be decoded combinationally from the dout register (no extra latency).
REQ-024 tick while run is low SHALL be ignored; dout holds and no tick is remembered.

Reset
REQ-025 Assertion of reset SHALL immediately force dout=0000, done=0 and load_err=0; zero then reads 1.
REQ-026 Reset asserted mid-count SHALL discard the count; after release the block is idle until a load is received.

Structure
REQ-027 The digit maxima (9, 5), the digit width (4) and the time width (16) SHALL be constants in the shared timer definitions header.
REQ-028 One sub-module, bcd_digit_down, SHALL implement a single BCD digit with max-value parameter, borrow-in, borrow-out, load and clear; it is instantiated four times.
REQ-029 done and load_err SHALL be registered outputs; no combinational path from inputs to outputs.

Verification
REQ-030 reset; load din=16'h0003, run=1, 3 ticks -> dout 0002, 0001, 0000; done pulses once after the third tick; zero=1.
REQ-031 load 16'h1000, run=1, 1 tick -> dout=16'h0959.
REQ-032 Count to 0000, then 2 more ticks -> dout stays 0000; no further done pulses.
REQ-033 din=16'h7A6C: CLAMP_INVALID=1 -> dout=16'h7959; CLAMP_INVALID=0 -> dout unchanged and load_err pulses once.
REQ-034 load, clear and tick in the same cycle with din=16'h0100 -> dout=0000 and done=0; then load and tick in the same cycle -> dout=16'h0100.
REQ-035 run=0 with 5 ticks -> dout unchanged; reset asserted between clock edges mid-count -> dout=0000 immediately.
